// File: rtl/edge_bbox_tracker.sv
// Edge bounding-box tracker: forwards an Avalon-ST video stream with one
// cycle of latency, tracks the box and count of above-threshold edge pixels
// per frame, and optionally draws the previous frame's box onto the output.
module edge_bbox_tracker #(
  parameter int unsigned IMAGE_W = 640,
  parameter int unsigned IMAGE_H = 480,
  parameter int unsigned COORD_W = 11
) (
  input  logic        clk,
  input  logic        reset,
  input  logic [23:0] sink_data,
  input  logic        sink_valid,
  output logic        sink_ready,
  input  logic        sink_sop,
  input  logic        sink_eop,
  output logic [23:0] source_data,
  output logic        source_valid,
  input  logic        source_ready,
  output logic        source_sop,
  output logic        source_eop,
  input  logic        s_chipselect,
  input  logic        s_read,
  input  logic        s_write,
  input  logic [2:0]  s_address,
  input  logic [31:0] s_writedata,
  output logic [31:0] s_readdata
);

  localparam logic [COORD_W-1:0] XLast = COORD_W'(IMAGE_W - 1);
  localparam logic [COORD_W-1:0] YEnd  = COORD_W'(IMAGE_H);

  logic [1:0]         r_ctrl;
  logic [7:0]         r_thresh;
  logic               r_in_pkt, r_is_video;
  logic [COORD_W-1:0] r_x, r_y;
  logic [COORD_W-1:0] r_min_x, r_max_x, r_min_y, r_max_y;
  logic [31:0]        r_hits;
  logic [COORD_W-1:0] r_bb_min_x, r_bb_max_x, r_bb_min_y, r_bb_max_y;
  logic [31:0]        r_bb_hits;
  logic               r_valid, r_done;
  logic [15:0]        r_frame_count;

  logic               w_xfer, w_pixel, w_video_sop, w_hit, w_latch, w_ovl;
  logic               w_rd, w_wr;
  logic [COORD_W-1:0] w_min_x, w_max_x, w_min_y, w_max_y;
  logic [31:0]        w_hits;
  logic [31:0]        w_rdata;

  assign sink_ready  = source_ready | ~source_valid;
  assign w_xfer      = sink_valid & sink_ready;
  assign w_video_sop = w_xfer & sink_sop & (sink_data[3:0] == 4'h0);
  assign w_pixel     = w_xfer & ~sink_sop & r_in_pkt & r_is_video;
  assign w_hit       = w_pixel & r_ctrl[0] & (r_y < YEnd) & (sink_data[7:0] >= r_thresh);
  // Latch on the eop of a video packet, including a header-only packet.
  assign w_latch     = r_ctrl[0] & w_xfer & sink_eop & (w_video_sop | w_pixel);
  assign w_rd        = s_chipselect & s_read;
  assign w_wr        = s_chipselect & s_write;

  // Next-state of the running per-frame statistics, including the current beat.
  always_comb begin
    w_min_x = r_min_x;
    w_max_x = r_max_x;
    w_min_y = r_min_y;
    w_max_y = r_max_y;
    w_hits  = r_hits;
    if (w_video_sop) begin
      w_min_x = '1;
      w_max_x = '0;
      w_min_y = '1;
      w_max_y = '0;
      w_hits  = '0;
    end else if (w_hit) begin
      if (r_x < r_min_x) w_min_x = r_x;
      if (r_x > r_max_x) w_max_x = r_x;
      if (r_y < r_min_y) w_min_y = r_y;
      if (r_y > r_max_y) w_max_y = r_y;
      if (r_hits != '1) w_hits = r_hits + 32'd1;
    end
  end

  // Overlay decision: current pixel lies on the latched box perimeter.
  always_comb begin
    w_ovl = 1'b0;
    if (w_pixel && r_ctrl[1] && r_valid) begin
      if (((r_x == r_bb_min_x) || (r_x == r_bb_max_x)) &&
          (r_y >= r_bb_min_y) && (r_y <= r_bb_max_y)) begin
        w_ovl = 1'b1;
      end
      if (((r_y == r_bb_min_y) || (r_y == r_bb_max_y)) &&
          (r_x >= r_bb_min_x) && (r_x <= r_bb_max_x)) begin
        w_ovl = 1'b1;
      end
    end
  end

  // Register read mux.
  always_comb begin
    w_rdata = '0;
    case (s_address)
      3'd0:    w_rdata = {30'd0, r_ctrl};
      3'd1:    w_rdata = {24'd0, r_thresh};
      3'd2:    w_rdata = (32'(r_bb_max_x) << 16) | 32'(r_bb_min_x);
      3'd3:    w_rdata = (32'(r_bb_max_y) << 16) | 32'(r_bb_min_y);
      3'd4:    w_rdata = r_bb_hits;
      3'd5:    w_rdata = {r_valid, 14'd0, r_done, r_frame_count};
      default: w_rdata = '0;
    endcase
  end

  // Output register stage; holds while stalled.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      source_valid <= 1'b0;
      source_sop   <= 1'b0;
      source_eop   <= 1'b0;
      source_data  <= '0;
    end else if (w_xfer) begin
      source_valid <= 1'b1;
      source_sop   <= sink_sop;
      source_eop   <= sink_eop;
      source_data  <= w_ovl ? 24'hFF0000 : sink_data;
    end else if (source_ready) begin
      source_valid <= 1'b0;
    end
  end

  // Packet parser: packet type and pixel coordinates.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_in_pkt   <= 1'b0;
      r_is_video <= 1'b0;
      r_x        <= '0;
      r_y        <= '0;
    end else if (w_xfer) begin
      if (sink_sop) begin
        r_in_pkt   <= ~sink_eop;
        r_is_video <= (sink_data[3:0] == 4'h0);
        r_x        <= '0;
        r_y        <= '0;
      end else if (r_in_pkt) begin
        if (sink_eop) r_in_pkt <= 1'b0;
        if (r_x == XLast) begin
          r_x <= '0;
          // Hold y past the frame so a runaway packet cannot wrap back in.
          if (r_y < YEnd) r_y <= r_y + 1'b1;
        end else begin
          r_x <= r_x + 1'b1;
        end
      end
    end
  end

  // Running stats and latched frame results.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_min_x       <= '0;
      r_max_x       <= '0;
      r_min_y       <= '0;
      r_max_y       <= '0;
      r_hits        <= '0;
      r_bb_min_x    <= '0;
      r_bb_max_x    <= '0;
      r_bb_min_y    <= '0;
      r_bb_max_y    <= '0;
      r_bb_hits     <= '0;
      r_valid       <= 1'b0;
      r_done        <= 1'b0;
      r_frame_count <= '0;
    end else begin
      r_min_x <= w_min_x;
      r_max_x <= w_max_x;
      r_min_y <= w_min_y;
      r_max_y <= w_max_y;
      r_hits  <= w_hits;
      if (w_latch) begin
        r_bb_min_x    <= w_min_x;
        r_bb_max_x    <= w_max_x;
        r_bb_min_y    <= w_min_y;
        r_bb_max_y    <= w_max_y;
        r_bb_hits     <= w_hits;
        r_valid       <= (w_hits != 32'd0);
        r_frame_count <= r_frame_count + 16'd1;
      end
      // Set from a latch wins over clear-on-read.
      if (w_latch) begin
        r_done <= 1'b1;
      end else if (w_rd && (s_address == 3'd5)) begin
        r_done <= 1'b0;
      end
    end
  end

  // Control registers and registered read data.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_ctrl     <= 2'b01;
      r_thresh   <= 8'h80;
      s_readdata <= '0;
    end else begin
      if (w_wr && (s_address == 3'd0)) r_ctrl   <= s_writedata[1:0];
      if (w_wr && (s_address == 3'd1)) r_thresh <= s_writedata[7:0];
      if (w_rd) s_readdata <= w_rdata;
    end
  end

endmodule

// File: tb/tb_edge_bbox_tracker.sv
// Directed self-checking bench for edge_bbox_tracker on a 4x3 image.
module tb_edge_bbox_tracker;

  localparam int W = 4;
  localparam int H = 3;
  localparam int N = W * H;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic [23:0] sink_data = '0;
  logic        sink_valid = 1'b0;
  logic        sink_ready;
  logic        sink_sop = 1'b0;
  logic        sink_eop = 1'b0;
  logic [23:0] source_data;
  logic        source_valid;
  logic        source_ready = 1'b1;
  logic        source_sop;
  logic        source_eop;
  logic        s_chipselect = 1'b0;
  logic        s_read = 1'b0;
  logic        s_write = 1'b0;
  logic [2:0]  s_address = '0;
  logic [31:0] s_writedata = '0;
  logic [31:0] s_readdata;

  int n_checks = 0;
  int n_errors = 0;

  logic [25:0] got_q[$];
  logic [25:0] exp_q[$];
  logic [23:0] pix[N];
  bit          ovl[N];
  bit          toggle = 1'b0;
  bit          stall_prev = 1'b0;
  logic [26:0] prev_out;
  logic [31:0] rd;

  edge_bbox_tracker #(.IMAGE_W(W), .IMAGE_H(H), .COORD_W(11)) dut (
    .clk(clk), .reset(reset),
    .sink_data(sink_data), .sink_valid(sink_valid), .sink_ready(sink_ready),
    .sink_sop(sink_sop), .sink_eop(sink_eop),
    .source_data(source_data), .source_valid(source_valid), .source_ready(source_ready),
    .source_sop(source_sop), .source_eop(source_eop),
    .s_chipselect(s_chipselect), .s_read(s_read), .s_write(s_write),
    .s_address(s_address), .s_writedata(s_writedata), .s_readdata(s_readdata)
  );

  always #5 clk = ~clk;

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
    end
  endtask

  // Downstream ready: constantly high, or toggling each cycle.
  always @(posedge clk) begin
    #1;
    source_ready = toggle ? ~source_ready : 1'b1;
  end

  // Output monitor: capture transfers and check stability while stalled.
  always @(negedge clk) begin
    if (reset) begin
      stall_prev = 1'b0;
    end else begin
      if (stall_prev)
        check_eq("stall_hold", 32'({source_valid, source_sop, source_eop, source_data}),
                 32'(prev_out));
      if (source_valid && source_ready) got_q.push_back({source_sop, source_eop, source_data});
      stall_prev = source_valid & ~source_ready;
      prev_out   = {source_valid, source_sop, source_eop, source_data};
    end
  end

  task automatic send_beat(input logic [23:0] d, input logic sop, input logic eop);
    bit acc = 1'b0;
    sink_data  = d;
    sink_sop   = sop;
    sink_eop   = eop;
    sink_valid = 1'b1;
    for (int n = 0; n < 100 && !acc; n++) begin
      @(negedge clk);
      acc = sink_ready;
      @(posedge clk);
      #1;
    end
    if (!acc) check_eq("sink_accept_timeout", 32'd0, 32'd1);
    exp_q.push_back({sop, eop, d});
  endtask

  task automatic idle(input int n);
    sink_valid = 1'b0;
    sink_sop   = 1'b0;
    sink_eop   = 1'b0;
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  // Header beat then N pixels; expected output carries overlay where marked.
  task automatic send_video();
    send_beat(24'h000000, 1'b1, 1'b0);
    for (int i = 0; i < N; i++) begin
      send_beat(pix[i], 1'b0, i == N - 1);
      if (ovl[i]) exp_q[exp_q.size() - 1] = {1'b0, i == N - 1, 24'hFF0000};
    end
    idle(6);
  endtask

  task automatic cmp_stream(input string tag);
    check_eq({tag, "_len"}, got_q.size(), exp_q.size());
    for (int i = 0; i < exp_q.size() && i < got_q.size(); i++)
      check_eq($sformatf("%s_beat%0d", tag, i), 32'(got_q[i]), 32'(exp_q[i]));
    got_q.delete();
    exp_q.delete();
  endtask

  task automatic mm_write(input logic [2:0] a, input logic [31:0] d);
    s_chipselect = 1'b1;
    s_write      = 1'b1;
    s_address    = a;
    s_writedata  = d;
    @(posedge clk);
    #1;
    s_chipselect = 1'b0;
    s_write      = 1'b0;
  endtask

  task automatic mm_read(input logic [2:0] a, output logic [31:0] d);
    s_chipselect = 1'b1;
    s_read       = 1'b1;
    s_address    = a;
    @(posedge clk);
    #1;
    s_chipselect = 1'b0;
    s_read       = 1'b0;
    d = s_readdata;
  endtask

  task automatic set_frame(input logic [23:0] fill);
    for (int i = 0; i < N; i++) begin
      pix[i] = fill;
      ovl[i] = 1'b0;
    end
  endtask

  task automatic check_test1(input string tag, input logic [31:0] status);
    mm_read(3'd2, rd); check_eq({tag, "_bbox_x"}, rd, 32'h0002_0001);
    mm_read(3'd3, rd); check_eq({tag, "_bbox_y"}, rd, 32'h0002_0000);
    mm_read(3'd4, rd); check_eq({tag, "_hits"},   rd, 32'd2);
    mm_read(3'd5, rd); check_eq({tag, "_status"}, rd, status);
  endtask

  initial begin
    // Reset state
    repeat (2) @(posedge clk);
    #1;
    check_eq("rst_source_valid", 32'(source_valid), 32'd0);
    check_eq("rst_readdata", s_readdata, 32'd0);
    reset = 1'b0;
    idle(2);
    mm_read(3'd0, rd); check_eq("rst_ctrl", rd, 32'h1);
    mm_read(3'd1, rd); check_eq("rst_thresh", rd, 32'h80);
    mm_read(3'd5, rd); check_eq("rst_status", rd, 32'h0);
    mm_read(3'd7, rd); check_eq("undef_addr", rd, 32'h0);
    mm_write(3'd1, 32'h40);
    mm_read(3'd1, rd); check_eq("thresh_rw", rd, 32'h40);
    mm_write(3'd1, 32'h80);
    mm_write(3'd4, 32'h1234);
    mm_read(3'd4, rd); check_eq("ro_write_ignored", rd, 32'h0);

    // Test 1: two hits at (1,0) and (2,2)
    set_frame(24'h0);
    pix[1]  = 24'h000090;
    pix[10] = 24'h000090;
    send_video();
    cmp_stream("t1_stream");
    check_test1("t1", 32'h8001_0001);

    // Test 2: same frame with downstream backpressure
    toggle = 1'b1;
    send_video();
    toggle = 1'b0;
    idle(2);
    cmp_stream("t2_stream");
    check_test1("t2", 32'h8001_0002);

    // Test 3: control packet passes through and leaves stats alone
    send_beat(24'h00000F, 1'b1, 1'b0);
    send_beat(24'h0000FF, 1'b0, 1'b0);
    send_beat(24'h0000FF, 1'b0, 1'b1);
    idle(4);
    cmp_stream("t3_stream");
    check_test1("t3", 32'h8000_0002);

    // Test 5: overlay of the previous box on an all-zero frame
    mm_write(3'd0, 32'h3);
    set_frame(24'h0);
    ovl[1] = 1'b1; ovl[2] = 1'b1; ovl[5] = 1'b1;
    ovl[6] = 1'b1; ovl[9] = 1'b1; ovl[10] = 1'b1;
    send_video();
    cmp_stream("t5_stream");
    mm_read(3'd5, rd); check_eq("t5_status", rd, 32'h0001_0003);
    mm_write(3'd0, 32'h1);

    // Test 4: nothing above threshold
    set_frame(24'h000010);
    send_video();
    cmp_stream("t4_stream");
    mm_read(3'd4, rd); check_eq("t4_hits", rd, 32'd0);
    mm_read(3'd5, rd); check_eq("t4_status", rd, 32'h0001_0004);
    mm_read(3'd5, rd); check_eq("t4_status_reread", rd, 32'h0000_0004);

    // Test 6: reset mid-frame, then a full frame
    set_frame(24'h0);
    pix[1]  = 24'h000090;
    pix[10] = 24'h000090;
    send_beat(24'h000000, 1'b1, 1'b0);
    for (int i = 0; i < 5; i++) send_beat(pix[i], 1'b0, 1'b0);
    check_eq("t6_valid_before_rst", 32'(source_valid), 32'd1);
    reset = 1'b1;
    sink_valid = 1'b0;
    #1;
    check_eq("t6_valid_in_rst", 32'(source_valid), 32'd0);
    @(posedge clk);
    #1;
    reset = 1'b0;
    idle(2);
    got_q.delete();
    exp_q.delete();
    mm_read(3'd0, rd); check_eq("t6_ctrl", rd, 32'h1);
    mm_read(3'd1, rd); check_eq("t6_thresh", rd, 32'h80);
    send_video();
    cmp_stream("t6_stream");
    check_test1("t6", 32'h8001_0001);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
